cordic_angle_feeder: RTL

CORDIC_ANGLE_FEEDER -- requirements
Module: cordic_angle_feeder

---
 rtl/cordic_angle_feeder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cordic_angle_feeder.sv
// Angle feeder/unfolder around a combinational CORDIC core: folds degrees into the first quadrant,
// waits for the core to settle, then restores signs. Optional macro: CORDIC_FEEDER_EXACT_AXIS_EN.
module cordic_angle_feeder #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [31:0] K_GAIN        = 32'd163007430,
  parameter logic [31:0] DEG2RAD       = 32'd4685079
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8:0]         in_deg,
  output logic signed [31:0] x_start,
  output logic signed [31:0] y_start,
  output logic signed [31:0] angle,
  input  logic signed [31:0] cosine_in,
  input  logic signed [31:0] sine_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] cos_out,
  output logic signed [31:0] sin_out,
  output logic [8:0]         out_deg,
  output logic               err
);

  localparam int unsigned W = 32;
  localparam logic signed [W-1:0] ONE = 32'sd268435456;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [8:0]  deg_q;
  logic        sc, ss;
  logic [6:0]  r_c;
  logic        sc_c, ss_c;
  logic        accept, legal, load_op, bad_req, capture, settle_done, exact_c;
  logic signed [W-1:0] base_cos, base_sin;

  // Quadrant fold: reduced angle in 0..90 plus sign flags (1 = positive)
  always_comb begin
    r_c  = 7'(in_deg);
    sc_c = 1'b1;
    ss_c = 1'b1;
    if (in_deg <= 9'd90) begin
      r_c = 7'(in_deg);
    end else if (in_deg <= 9'd180) begin
      r_c  = 7'(9'd180 - in_deg);
      sc_c = 1'b0;
    end else if (in_deg <= 9'd270) begin
      r_c  = 7'(in_deg - 9'd180);
      sc_c = 1'b0;
      ss_c = 1'b0;
    end else begin
      r_c  = 7'(9'd360 - in_deg);
      ss_c = 1'b0;
    end
  end

`ifdef CORDIC_FEEDER_EXACT_AXIS_EN
  logic exact, axis_x;
  // On an axis the reduced angle is 0 (x axis) or 90 (y axis); signs come from the fold
  assign exact_c  = (r_c == 7'd0) || (r_c == 7'd90);
  assign base_cos = exact ? (axis_x ? ONE : '0) : cosine_in;
  assign base_sin = exact ? (axis_x ? '0 : ONE) : sine_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact  <= 1'b0;
      axis_x <= 1'b0;
    end else if (load_op) begin
      exact  <= exact_c;
      axis_x <= (r_c == 7'd0);
    end
  end
`else
  assign exact_c  = 1'b0;
  assign base_cos = cosine_in;
  assign base_sin = sine_in;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_op) state_nxt = exact_c ? CAPTURE : SETTLE;
      SETTLE:  if (settle_done) state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control decodes; in_ready must drop immediately while reset is held
  always_comb begin
    in_ready    = (state == IDLE) && rst_n;
    accept      = in_valid && in_ready;
    legal       = (in_deg < 9'd360);
    load_op     = accept && legal;
    bad_req     = accept && !legal;
    capture     = (state == CAPTURE);
    settle_done = (cnt == 4'(SETTLE_CYCLES - 1));
  end

  // Operand, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_start   <= '0;
      y_start   <= '0;
      angle     <= '0;
      cos_out   <= '0;
      sin_out   <= '0;
      out_deg   <= '0;
      deg_q     <= '0;
      cnt       <= '0;
      sc        <= 1'b1;
      ss        <= 1'b1;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= bad_req;
      if (load_op) begin
        x_start <= K_GAIN;
        y_start <= '0;
        angle   <= W'(r_c) * DEG2RAD;
        deg_q   <= in_deg;
        sc      <= sc_c;
        ss      <= ss_c;
        cnt     <= '0;
      end else if (state == SETTLE) begin
        cnt <= cnt + 4'd1;
      end
      if (capture) begin
        cos_out   <= sc ? base_cos : W'(-base_cos);
        sin_out   <= ss ? base_sin : W'(-base_sin);
        out_deg   <= deg_q;
        out_valid <= 1'b1;
      end else if ((state == HOLD) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
